// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int unsigned BCD_DIGIT_W    = 4;
  localparam int unsigned BCD_ADJ_THRESH = 5;
  localparam int unsigned BCD_ADJ_ADD    = 3;

  // Smallest digit count d with 10^d > 2^width - 1.
  function automatic int unsigned min_digits(input int unsigned width);
    longint unsigned maxv;
    longint unsigned pow10;
    int unsigned     d;
    maxv  = (64'd1 << width) - 64'd1;
    pow10 = 64'd10;
    d     = 1;
    for (int i = 0; i < 20; i++) begin
      if (pow10 <= maxv) begin
        d     = d + 1;
        pow10 = pow10 * 64'd10;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bin2bcd_seq_digit_adj.sv
// One double-dabble digit slice: add 3 when the digit is 5 or more (no carry out).
module bcd_digit_adj
  import bin2bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] d,
  output logic [BCD_DIGIT_W-1:0] q_c
);

  always_comb begin
    q_c = d;
    if (d >= BCD_DIGIT_W'(BCD_ADJ_THRESH)) q_c = d + BCD_DIGIT_W'(BCD_ADJ_ADD);
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [WIDTH-1:0]                bin,
  output logic                            busy,
  output logic                            done,
  output logic [BCD_DIGIT_W*DIGITS-1:0]   bcd
);

  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  if (DIGITS < min_digits(WIDTH)) begin : g_bad_digits
    $fatal(1, "bin2bcd_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   adj_c;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_d, done_d;
  logic [BCD_W-1:0]   bcd_d;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .d   (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .q_c (adj_c[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      busy      <= busy_d;
      done      <= done_d;
      bcd       <= bcd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    bcd_d     = bcd;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d   = bin;
          scratch_d = '0;
          cnt_d     = CNT_W'(WIDTH);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        // Adjust every digit first, then shift the combined register left.
        {scratch_d, shreg_d} = {adj_c, shreg_q} << 1;
        cnt_d  = cnt_q - CNT_W'(1);
        busy_d = 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = scratch_d;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: default 8-bit/3-digit instance plus a 10-bit/4-digit instance.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  bin;
  logic        busy, done;
  logic [11:0] bcd;

  logic        start10;
  logic [9:0]  bin10;
  logic        busy10, done10;
  logic [15:0] bcd10;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int last_cyc = 0;
  bit have_last = 1'b0;
  bit sweep_on = 1'b0;

  logic [11:0] exp_q[$];
  logic [15:0] exp10_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u_dut (
    .clk(clk), .rst(rst), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd)
  );

  bin2bcd_seq #(.WIDTH(10), .DIGITS(4)) u_dut10 (
    .clk(clk), .rst(rst), .start(start10), .bin(bin10),
    .busy(busy10), .done(done10), .bcd(bcd10)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Monitors: pop the expected result whenever a done pulse is seen.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        chk("bcd", int'(bcd), int'(exp_q.pop_front()));
      end
      if (sweep_on) begin
        if (have_last) chk("done_period", cyc - last_cyc, 9);
        last_cyc  = cyc;
        have_last = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (done10) begin
      if (exp10_q.size() == 0) chk("unexpected_done10", 1, 0);
      else chk("bcd10", int'(bcd10), int'(exp10_q.pop_front()));
    end
  end

  task automatic convert(input logic [7:0] v, input logic [11:0] exp);
    int n, nbusy;
    start = 1'b1;
    bin   = v;
    exp_q.push_back(exp);
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    nbusy = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
      if (done) break;
    end
    chk("latency", n, 9);
    chk("busy_cycles", nbusy, 8);
    @(negedge clk);
    chk("done_single", int'(done), 0);
  endtask

  task automatic convert10(input logic [9:0] v, input logic [15:0] exp);
    int n;
    start10 = 1'b1;
    bin10   = v;
    exp10_q.push_back(exp);
    @(posedge clk);
    #1 start10 = 1'b0;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (done10) break;
    end
    chk("latency10", n, 11);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bin = '0; start10 = 1'b0; bin10 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_bcd", int'(bcd), 0);
    rst = 1'b0;
    @(negedge clk);

    convert(8'd0,   12'h000);
    convert(8'd255, 12'h255);
    convert(8'd99,  12'h099);
    convert(8'd100, 12'h100);
    convert(8'd9,   12'h009);

    // Second start during SHIFT must be ignored.
    start = 1'b1; bin = 8'd42;
    exp_q.push_back(12'h042);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b1; bin = 8'd200;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (30) @(negedge clk);
    chk("ignored_start_queue", exp_q.size(), 0);
    chk("ignored_start_bcd", int'(bcd), 12'h042);

    // Reset in the middle of a conversion abandons it.
    start = 1'b1; bin = 8'd137;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_bcd", int'(bcd), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    convert(8'd137, 12'h137);

    // Back-to-back sweep with start held high; bin moves on right after each accept.
    have_last = 1'b0;
    sweep_on  = 1'b1;
    for (int v = 0; v < 256; v++) begin
      start = 1'b1;
      bin   = 8'(v);
      exp_q.push_back(ref_bcd(v));
      @(posedge clk);
      #1 bin = 8'(v + 77);
      repeat (8) @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    sweep_on = 1'b0;
    chk("sweep_queue", exp_q.size(), 0);

    convert10(10'd1023, 16'h1023);
    convert10(10'd512,  16'h0512);
    convert10(10'd0,    16'h0000);

    repeat (5) @(negedge clk);
    chk("final_queue", exp_q.size(), 0);
    chk("final_queue10", exp10_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) method, one bit per clock. It sits directly downstream of the lab up/down counter. It accepts the counter's WIDTH-bit `count` value on a start strobe and returns packed BCD digits for the seven-segment display driver. It trades latency for area: one digit-adjust slice per digit, no wide combinational tree.

## Interface
- `WIDTH`, default 8: binary input width; must equal the upstream counter width.
- `DIGITS`, default 3: BCD output digits. The design requires 10^DIGITS > 2^WIDTH − 1, checked at elaboration (fatal if violated).
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  request a conversion of `bin`; sampled only in IDLE.
- `bin`  in  WIDTH  unsigned binary operand; captured on the accepted start edge only.
- `busy`  out  1  high while a conversion is in progress (state ≠ IDLE).
- `done`  out  1  single-cycle pulse; `bcd` is valid and updated in this cycle.
- `bcd`  out  4*DIGITS  packed BCD, digit 0 = bits [3:0] (units); holds last result until the next `done`.

## Operation
- States: IDLE, SHIFT.
- **IDLE:** `busy`=0. On `start`=1:
  - load the shift register with `bin`;
  - clear the BCD scratch;
  - set the iteration counter to WIDTH;
  - go to SHIFT.
- **SHIFT:** each cycle:
  - every scratch digit ≥ 5 gets +3 (4-bit, no carry out);
  - then {scratch, shift register} shifts left by 1;
  - the iteration counter decrements.
- When the counter is 1 (final shift):
  - the shifted scratch is written to `bcd`;
  - `done`<=1;
  - state goes to IDLE.
- Iteration counter width is $clog2(WIDTH+1) bits. Scratch width is 4*DIGITS. No value can exceed the digit range, given the parameter check.
- `start` while busy: ignored, no queuing. `bin` changes during SHIFT: no effect.
- `start` high in the `done` cycle: accepted, because the state is already IDLE.
- `start` held high continuously: back-to-back conversions.
- Reset values:
  - `busy`=0, `done`=0, `bcd`=0;
  - state IDLE;
  - scratch and shift register 0.
- Reset mid-conversion: the conversion is abandoned, no `done` pulse, and `bcd` returns to 0.

## Timing
- `start` sampled at edge E0 → `busy`=1 from E0 to E_WIDTH.
- Shifts occur at edges E1..E_WIDTH.
- `done`=1 and new `bcd` are visible in the cycle after E_WIDTH, with `busy`=0 in that same cycle.
- Latency: WIDTH clock edges from the accepting edge to `done` visible.
- Throughput: one conversion per WIDTH+1 cycles with `start` held high.
- `done` is high for exactly one cycle; `bcd` changes only on a `done` edge or reset.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Package `bin2bcd_pkg`:
  - `state_t` enum {IDLE, SHIFT};
  - `BCD_DIGIT_W` = 4;
  - constant `BCD_ADJ_THRESH` = 5 and `BCD_ADJ_ADD` = 3;
  - function `min_digits(width)` used by the elaboration check.
- Sub-module `bcd_digit_adj`: a combinational 4-bit add-3-if-≥5 slice, instantiated DIGITS times via generate.
- Top module holds the FSM, iteration counter, shift/scratch registers and output registers.

## Test plan
- Defaults; `bin`=0, `start` pulse → after 8 edges, `done`=1 with `bcd`=12'h000; `busy` high for exactly 8 cycles.
- `bin`=255 → `bcd`=12'h255. `bin`=99 → 12'h099. `bin`=100 → 12'h100. `bin`=9 → 12'h009.
- `start` pulse with `bin`=42, then `start`=1 and `bin`=200 in cycle 3 of SHIFT → single `done`, `bcd`=12'h042; the second start is ignored.
- `start` held high, `bin` stepped 0..255 by the upstream counter each accepted edge → a `done` every 9 cycles, each result equal to the decimal value captured; all 256 values checked against a reference model.
- `rst` asserted at SHIFT cycle 4 of `bin`=137 → next cycle `busy`=0, `done`=0, `bcd`=0; no `done` follows. A new start with `bin`=137 then yields 12'h137.
- WIDTH=10, DIGITS=4, `bin`=1023 → `bcd`=16'h1023 after 10 edges. WIDTH=10, DIGITS=3 → elaboration fatal.
